rr_arb2: RTL and testbench
==========================

RR_ARB2 -- requirements
Module: rr_arb2

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits of each input and the output.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous to clk and active-low.
REQ-004 a_valid  input  1  source A beat present.
REQ-005 a_data  input  DATA_W  source A payload.
REQ-006 a_last  input  1  final beat of the source A packet.
REQ-007 a_ready  output  1  source A beat accepted this cycle when a_valid is also high.
REQ-008 b_valid, b_data, b_last, b_ready SHALL mirror REQ-004..007 for source B.
REQ-009 y_valid  output  1  output register holds a beat.
REQ-010 y_data  output  DATA_W  registered payload.
REQ-011 y_last  output  1  registered last flag.
REQ-012 sel  output  1  source of the held beat (0=A, 1=B), registered; it drives the downstream 2:1 select with sel=1 choosing B.
REQ-013 y_ready  input  1  downstream accepts the beat when y_valid is also high.

Function
REQ-014 Load enable ld = !y_valid || y_ready; no input beat SHALL be accepted when ld=0.
REQ-015 FSM states: IDLE, LOCK_A, LOCK_B.
REQ-016 In IDLE with ld=1 and only one valid, that source SHALL be granted.
REQ-017 In IDLE with ld=1 and both valid, the source opposite the 1-bit pointer last_src SHALL be granted (round-robin).
REQ-018 In IDLE the granted ready SHALL be high combinationally in the same cycle, and the other ready SHALL be low.
REQ-019 When a granted beat transfers with last=0, the FSM SHALL move to LOCK_A or LOCK_B for that source.
REQ-020 When a granted beat transfers with last=1, the FSM SHALL remain in or return to IDLE, and last_src SHALL be set to that source.
REQ-021 In LOCK_X only X ready = ld, and the other ready SHALL be 0 even if that source is valid.
REQ-022 The lock SHALL persist across cycles where X valid is low (gaps); no interleaving of packets.
REQ-023 An accepted beat SHALL appear on y_data/y_last/sel with y_valid=1 on the next clk edge (latency 1 cycle).
REQ-024 Full throughput SHALL be one beat per cycle when y_ready stays high.
REQ-025 With y_valid=1 and y_ready=0, y_data, y_last and sel SHALL hold stable and all readies SHALL be 0.
REQ-026 On a transfer of the last beat, if the other source is valid, its first beat SHALL be accepted in the next cycle (no dead cycle beyond IDLE decision).
REQ-027 When y_ready=1 and no input is accepted, y_valid SHALL fall to 0 at the next edge.

Reset
REQ-028 While rst_n=0 at a clk edge: state=IDLE, last_src=B (so A wins the first contention), y_valid=0, y_data=0, y_last=0, sel=0.
REQ-029 During reset, a_ready and b_ready SHALL be 0.
REQ-030 Reset mid-packet SHALL discard the lock and the held beat, with no partial-packet recovery.

Structure
REQ-031 Package rr_arb2_pkg SHALL hold the FSM state enumeration and the constants SRC_A=0 and SRC_B=1.
REQ-032 There SHALL be no sub-module; the input payload select and the output register are inline.

Verification
REQ-033 Reset release, A sends 1-beat packet 0x3C (last=1), y_ready=1 -> next cycle y_valid=1, y_data=0x3C, sel=0, y_last=1.
REQ-034 A and B both valid from IDLE after reset, 1-beat packets 0x11/0x22 -> outputs 0x11(sel0) then 0x22(sel1) on consecutive cycles.
REQ-035 A 3-beat packet 0xA0,0xA1,0xA2 with a 1-cycle a_valid gap and B valid throughout -> b_ready stays 0 until 0xA2 accepted; B first beat output the cycle after 0xA2 appears.
REQ-036 y_ready held low 3 cycles with beat 0x55 held -> y_data=0x55 and sel stable, readies 0, no beat lost or duplicated after release.
REQ-037 rst_n=0 asserted mid-packet in LOCK_B -> next edge y_valid=0, state IDLE, and a subsequent A packet is granted immediately.
REQ-038 Random valid/ready stress over 10k cycles -> per-source order preserved, packets never interleaved, grants alternate under constant contention.

Source files
------------

// File: rtl/rr_arb2_pkg.sv
// rr_arb2 shared types: FSM state encoding and source ids.
// Source ids double as the sel value (0=A, 1=B).
package rr_arb2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: packet-atomic round-robin 2:1 arbiter with a registered output.
// Ports: clk, rst_n (sync, active-low); a_*/b_* valid/data/last/ready
// sources; y_valid/y_data/y_last/sel registered output; y_ready from sink.
module rr_arb2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    output logic              y_last,
    output logic              sel,
    input  logic              y_ready
);
    import rr_arb2_pkg::*;

    state_t state, state_nx;
    logic   last_src, last_src_nx;
    logic   ld;
    logic   grant_a, grant_b;
    logic   take_a, take_b, take;

    // Output register can load when empty or draining this cycle.
    assign ld = !y_valid || y_ready;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        unique case (state)
            IDLE: begin
                // Contention goes to the source that did not finish last.
                if (a_valid && (!b_valid || last_src == SRC_B))
                    grant_a = 1'b1;
                else if (b_valid)
                    grant_b = 1'b1;
            end
            LOCK_A:  grant_a = 1'b1;
            LOCK_B:  grant_b = 1'b1;
            default: ;
        endcase
    end

    // Readies are forced low while reset is held.
    assign a_ready = rst_n && ld && grant_a;
    assign b_ready = rst_n && ld && grant_b;

    assign take_a = a_valid && a_ready;
    assign take_b = b_valid && b_ready;
    assign take   = take_a || take_b;

    always_comb begin
        state_nx    = state;
        last_src_nx = last_src;
        unique case (1'b1)
            take_a: begin
                if (a_last) begin
                    state_nx    = IDLE;
                    last_src_nx = SRC_A;
                end else begin
                    state_nx    = LOCK_A;
                end
            end
            take_b: begin
                if (b_last) begin
                    state_nx    = IDLE;
                    last_src_nx = SRC_B;
                end else begin
                    state_nx    = LOCK_B;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_src <= SRC_B;
            y_valid  <= 1'b0;
            y_data   <= '0;
            y_last   <= 1'b0;
            sel      <= SRC_A;
        end else begin
            state    <= state_nx;
            last_src <= last_src_nx;
            if (ld) begin
                y_valid <= take;
                if (take) begin
                    y_data <= take_b ? b_data : a_data;
                    y_last <= take_b ? b_last : a_last;
                    sel    <= take_b ? SRC_B : SRC_A;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_arb2.sv
// rr_arb2 bench: directed scenarios plus a randomized stress run
// against a behavioural arbitration model and per-source scoreboards.
module tb_rr_arb2;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, a_last, a_ready;
    logic [DW-1:0] a_data;
    logic          b_valid, b_last, b_ready;
    logic [DW-1:0] b_data;
    logic          y_valid, y_last, sel, y_ready;
    logic [DW-1:0] y_data;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb2 #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .sel(sel),
        .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drv_a(input logic v, input logic [DW-1:0] d, input logic l);
        a_valid = v; a_data = d; a_last = l;
    endtask

    task automatic drv_b(input logic v, input logic [DW-1:0] d, input logic l);
        b_valid = v; b_data = d; b_last = l;
    endtask

    task automatic chk_y(input string tag, input logic [DW-1:0] d,
                         input logic s, input logic l);
        chk({tag, "_v"}, y_valid, 1'b1);
        chk({tag, "_d"}, y_data, d);
        chk({tag, "_s"}, sel, s);
        chk({tag, "_l"}, y_last, l);
    endtask

    // Stress-run state: pending beats ({last,data}) and expected outputs.
    logic [DW:0] qa[$], qb[$], ea[$], eb[$];

    task automatic add_pkt(input int s);
        int len;
        logic [DW:0] beat;
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
            beat = {(i == len - 1), DW'($urandom)};
            if (s == 0) begin qa.push_back(beat); ea.push_back(beat); end
            else        begin qb.push_back(beat); eb.push_back(beat); end
        end
    endtask

    initial begin
        bit          pres[2];
        bit          v[2], er[2], acc[2], lst[2];
        logic [DW-1:0] dat[2];
        int          owner;
        bit          m_last, m_yv, m_yl, m_sel, ld, open, open_src;
        logic [DW-1:0] m_yd;
        logic [DW:0] e;
        int          w, lim;

        rst_n = 1'b0;
        y_ready = 1'b1;
        drv_a(1'b1, 8'h99, 1'b1);
        drv_b(1'b1, 8'h98, 1'b1);

        // Reset state and readies held low during reset.
        tick(); tick();
        settle();
        chk("rst_yv", y_valid, 1'b0);
        chk("rst_yd", y_data, 8'h00);
        chk("rst_sel", sel, 1'b0);
        chk("rst_yl", y_last, 1'b0);
        chk("rst_ar", a_ready, 1'b0);
        chk("rst_br", b_ready, 1'b0);

        // Single-beat packet from A.
        rst_n = 1'b1;
        drv_a(1'b1, 8'h3C, 1'b1);
        drv_b(1'b0, 8'h00, 1'b0);
        settle();
        chk("t33_ar", a_ready, 1'b1);
        tick();
        drv_a(1'b0, 8'h00, 1'b0);
        settle();
        chk_y("t33", 8'h3C, 1'b0, 1'b1);

        // Re-reset so the first contention goes to A.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drv_a(1'b1, 8'h11, 1'b1);
        drv_b(1'b1, 8'h22, 1'b1);
        settle();
        chk("t34_ar", a_ready, 1'b1);
        chk("t34_br", b_ready, 1'b0);
        tick();
        drv_a(1'b0, 8'h00, 1'b0);
        settle();
        chk_y("t34a", 8'h11, 1'b0, 1'b1);
        chk("t34_br2", b_ready, 1'b1);
        tick();
        drv_b(1'b0, 8'h00, 1'b0);
        settle();
        chk_y("t34b", 8'h22, 1'b1, 1'b1);
        tick();
        settle();
        chk("t34_drain", y_valid, 1'b0);

        // A 3-beat packet with a gap; B must wait for the last beat.
        drv_a(1'b1, 8'hA0, 1'b0);
        drv_b(1'b1, 8'hB0, 1'b1);
        settle();
        chk("t35_ar0", a_ready, 1'b1);
        chk("t35_br0", b_ready, 1'b0);
        tick();
        drv_a(1'b0, 8'h00, 1'b0);
        settle();
        chk("t35_br1", b_ready, 1'b0);
        chk_y("t35a0", 8'hA0, 1'b0, 1'b0);
        tick();
        drv_a(1'b1, 8'hA1, 1'b0);
        settle();
        chk("t35_ar2", a_ready, 1'b1);
        chk("t35_br2", b_ready, 1'b0);
        tick();
        drv_a(1'b1, 8'hA2, 1'b1);
        settle();
        chk("t35_br3", b_ready, 1'b0);
        chk_y("t35a1", 8'hA1, 1'b0, 1'b0);
        tick();
        drv_a(1'b0, 8'h00, 1'b0);
        settle();
        chk_y("t35a2", 8'hA2, 1'b0, 1'b1);
        chk("t35_br4", b_ready, 1'b1);
        tick();
        drv_b(1'b0, 8'h00, 1'b0);
        settle();
        chk_y("t35b0", 8'hB0, 1'b1, 1'b1);
        tick();

        // Output stall holds the beat and blocks every source.
        drv_a(1'b1, 8'h55, 1'b1);
        tick();
        drv_a(1'b1, 8'h66, 1'b1);
        drv_b(1'b1, 8'h77, 1'b1);
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_y("t36_hold", 8'h55, 1'b0, 1'b1);
            chk("t36_ar", a_ready, 1'b0);
            chk("t36_br", b_ready, 1'b0);
            tick();
        end
        y_ready = 1'b1;
        settle();
        chk_y("t36_rel", 8'h55, 1'b0, 1'b1);
        chk("t36_br5", b_ready, 1'b1);
        chk("t36_ar5", a_ready, 1'b0);
        tick();
        drv_b(1'b0, 8'h00, 1'b0);
        settle();
        chk_y("t36b", 8'h77, 1'b1, 1'b1);
        chk("t36_ar6", a_ready, 1'b1);
        tick();
        drv_a(1'b0, 8'h00, 1'b0);
        settle();
        chk_y("t36a", 8'h66, 1'b0, 1'b1);
        tick();

        // Reset in the middle of a B packet drops the lock.
        drv_b(1'b1, 8'hC0, 1'b0);
        settle();
        chk("t37_br0", b_ready, 1'b1);
        tick();
        drv_b(1'b1, 8'hC1, 1'b0);
        drv_a(1'b1, 8'hD0, 1'b1);
        settle();
        chk("t37_lock_ar", a_ready, 1'b0);
        chk("t37_lock_br", b_ready, 1'b1);
        tick();
        rst_n = 1'b0;
        settle();
        chk("t37_rst_ar", a_ready, 1'b0);
        chk("t37_rst_br", b_ready, 1'b0);
        tick();
        settle();
        chk("t37_yv", y_valid, 1'b0);
        rst_n = 1'b1;
        drv_b(1'b1, 8'hC2, 1'b0);
        settle();
        chk("t37_ar", a_ready, 1'b1);
        chk("t37_br", b_ready, 1'b0);
        tick();
        drv_a(1'b0, 8'h00, 1'b0);
        drv_b(1'b0, 8'h00, 1'b0);
        settle();
        chk_y("t37a", 8'hD0, 1'b0, 1'b1);

        // Randomized stress; the final stretch keeps both sources busy.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        owner = 0; m_last = 1'b1; m_yv = 1'b0; m_yd = '0;
        m_yl = 1'b0; m_sel = 1'b0; open = 1'b0; open_src = 1'b0;
        pres[0] = 1'b0; pres[1] = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            lim = (cyc >= 9000) ? 1 : 0;
            y_ready = (lim == 1) ? 1'b1 : ($urandom % 4 != 0);
            for (int s = 0; s < 2; s++) begin
                if (!pres[s]) begin
                    if (s == 0 && qa.size() == 0) add_pkt(0);
                    if (s == 1 && qb.size() == 0) add_pkt(1);
                    if (lim == 1 || $urandom % 3 != 0) pres[s] = 1'b1;
                end
                e = (s == 0) ? qa[0] : qb[0];
                v[s] = pres[s];
                dat[s] = pres[s] ? e[DW-1:0] : '0;
                lst[s] = pres[s] ? e[DW] : 1'b0;
            end
            drv_a(v[0], dat[0], lst[0]);
            drv_b(v[1], dat[1], lst[1]);
            settle();

            // Which source may move a beat this cycle, from the rules.
            ld = !m_yv || y_ready;
            er[0] = 1'b0; er[1] = 1'b0;
            if (owner != 0) begin
                er[owner-1] = ld;
            end else if (v[0] || v[1]) begin
                w = (v[0] && v[1]) ? (m_last ? 0 : 1) : (v[0] ? 0 : 1);
                er[w] = ld;
            end
            chk("st_ar", a_ready, er[0]);
            chk("st_br", b_ready, er[1]);
            chk("st_yv", y_valid, m_yv);
            if (m_yv) begin
                chk("st_yd", y_data, m_yd);
                chk("st_yl", y_last, m_yl);
                chk("st_sel", sel, m_sel);
            end

            // Per-source order and packet atomicity on the output side.
            if (y_valid && y_ready) begin
                if (open) chk("st_interleave", sel, open_src);
                if (sel == 1'b0 && ea.size() > 0) begin
                    e = ea.pop_front();
                    chk("st_ord_a", {y_last, y_data}, e);
                end else if (sel == 1'b1 && eb.size() > 0) begin
                    e = eb.pop_front();
                    chk("st_ord_b", {y_last, y_data}, e);
                end else begin
                    chk("st_extra_beat", 1'b1, 1'b0);
                end
                open = !y_last;
                open_src = sel;
            end

            for (int s = 0; s < 2; s++) acc[s] = v[s] && er[s];
            if (ld) begin
                m_yv = acc[0] || acc[1];
                if (acc[0] || acc[1]) begin
                    w = acc[1] ? 1 : 0;
                    m_yd = dat[w]; m_yl = lst[w]; m_sel = w[0];
                    if (lst[w]) begin owner = 0; m_last = w[0]; end
                    else        owner = w + 1;
                end
            end
            if (acc[0]) begin void'(qa.pop_front()); pres[0] = 1'b0; end
            if (acc[1]) begin void'(qb.pop_front()); pres[1] = 1'b0; end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
